// File: rtl/i2c_wm8731_cfg_ctrl.sv
// i2c_wm8731_cfg_ctrl: walks a config LUT and writes each word to a WM8731 as a 3-byte I2C frame
module i2c_wm8731_cfg_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int I2C_FREQ   = 100_000,
    parameter int INIT_DELAY = 1_000_000,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  lut_index,
    input  logic [23:0] lut_data,
    input  logic [3:0]  lut_size,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        busy,
    output logic        config_done,
    output logic        ack_err
);
    localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;
    localparam int DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_LOAD, S_START, S_BIT, S_ACK, S_STOP, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t          r_state, w_state_nx;
    logic [DW-1:0]   r_cnt;
    logic [QW-1:0]   r_q;
    logic [1:0]      r_ph;
    logic [2:0]      r_bit;
    logic [1:0]      r_byte;
    logic [23:0]     r_sh;
    logic            r_nack;
    logic [RW-1:0]   r_retry;
    logic [3:0]      r_index;
    logic            w_q_end, w_ph_end, w_framing, w_last_idx, w_scl, w_sda_lo;

    assign w_q_end    = r_q == QW'(Q - 1);
    assign w_ph_end   = w_q_end && r_ph == 2'd3;
    assign w_framing  = r_state == S_START || r_state == S_BIT || r_state == S_ACK || r_state == S_STOP;
    assign w_last_idx = ({1'b0, r_index} + 5'd1) == {1'b0, lut_size};

    assign lut_index   = r_index;
    assign i2c_sclk    = w_scl;
    assign i2c_sdat    = w_sda_lo ? 1'b0 : 1'bz;
    assign busy        = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign config_done = r_state == S_DONE;
    assign ack_err     = r_state == S_ERR;

    // State register; reset abandons any frame and restarts from IDLE
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next state and bus levels; SCL high with SDA released unless a frame is on the wire
    always_comb begin
        w_state_nx = r_state;
        w_scl      = 1'b1;
        w_sda_lo   = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nx = S_WAIT;
            S_WAIT:  w_state_nx = (r_cnt == DW'(INIT_DELAY - 1)) ? S_LOAD : S_WAIT;
            S_LOAD:  w_state_nx = (lut_size == 4'd0) ? S_DONE : S_START;
            S_START: begin
                w_sda_lo   = r_ph[1];
                w_state_nx = w_ph_end ? S_BIT : S_START;
            end
            S_BIT: begin
                w_scl      = r_ph == 2'd1 || r_ph == 2'd2;
                w_sda_lo   = !r_sh[23];
                w_state_nx = !w_ph_end ? S_BIT : (r_bit == 3'd7) ? S_ACK : S_BIT;
            end
            S_ACK: begin
                w_scl      = r_ph == 2'd1 || r_ph == 2'd2;
                w_state_nx = !w_ph_end ? S_ACK : (r_byte == 2'd2) ? S_STOP : S_BIT;
            end
            S_STOP: begin
                w_scl      = r_ph != 2'd0;
                w_sda_lo   = !r_ph[1];
                w_state_nx = w_ph_end ? S_NEXT : S_STOP;
            end
            S_NEXT:  w_state_nx = r_nack ? ((r_retry >= RW'(MAX_RETRY)) ? S_ERR : S_LOAD)
                                         : (w_last_idx ? S_DONE : S_LOAD);
            S_DONE,
            S_ERR:   w_state_nx = start ? S_WAIT : r_state;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Datapath: delay and quarter-period timing, shift register, ACK tracking, index and retries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_q     <= '0;
            r_ph    <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_sh    <= '0;
            r_nack  <= 1'b0;
            r_retry <= '0;
            r_index <= '0;
        end else begin
            // the IDLE cycle counts toward the power-up delay so the first frame is not late
            r_cnt <= (r_state == S_IDLE) ? DW'(1) : (r_state == S_WAIT) ? r_cnt + DW'(1) : '0;
            r_q   <= (w_framing && !w_q_end) ? r_q + QW'(1) : '0;
            r_ph  <= !w_framing ? 2'd0 : w_q_end ? r_ph + 2'd1 : r_ph;
            if (r_state == S_LOAD) begin
                r_sh   <= lut_data;
                r_bit  <= '0;
                r_byte <= '0;
                r_nack <= 1'b0;
            end
            if (r_state == S_BIT && w_ph_end) begin
                r_sh  <= {r_sh[22:0], 1'b0};
                r_bit <= r_bit + 3'd1;
            end
            if (r_state == S_ACK && r_ph == 2'd1 && w_q_end) r_nack <= r_nack | i2c_sdat;
            if (r_state == S_ACK && w_ph_end) r_byte <= r_byte + 2'd1;
            if (r_state == S_NEXT) begin
                r_retry <= r_nack ? r_retry + RW'(1) : '0;
                // index stays on the last entry at DONE so the LUT bus never sees lut_size
                if (!r_nack && !w_last_idx) r_index <= r_index + 4'd1;
            end
            if ((r_state == S_DONE || r_state == S_ERR) && start) begin
                r_index <= '0;
                r_retry <= '0;
            end
        end
    end
endmodule
